cfg_stream_loader: RTL and testbench

CFG_STREAM_LOADER -- requirements
Module: cfg_stream_loader

---
 rtl/cfg_stream_loader.sv | 150 +++++++++++++++
 tb/tb_cfg_stream_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : cfg_stream_loader
// Purpose  : Accepts a header word (target + bit length) followed by payload
//            words, and serialises the payload LSB-first onto a single
//            configuration bit line qualified by an SMU or SRU valid strobe.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   cfgClk             in   clock, rising edge
//   rst                in   asynchronous active-high reset
//   wordIn[WORD_W]     in   header or payload word
//   wordValid          in   wordIn valid
//   wordReady          out  word accepted when wordValid & wordReady
//   abort              in   synchronous cancel, returns to IDLE
//   bitstreamSerialOut out  serial configuration bit (0 when not valid)
//   smuStreamValid     out  serial bit belongs to the SMU
//   sruStreamValid     out  serial bit belongs to the SRU
//   busy               out  FSM not in IDLE
//   done               out  one-cycle pulse on normal completion
//   err                out  one-cycle pulse on rejected header
// ============================================================================
module cfg_stream_loader #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              cfgClk,
  input  logic              rst,
  input  logic [WORD_W-1:0] wordIn,
  input  logic              wordValid,
  output logic              wordReady,
  input  logic              abort,
  output logic              bitstreamSerialOut,
  output logic              smuStreamValid,
  output logic              sruStreamValid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int c_BCNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [c_BCNT_W-1:0] bcnt_q, bcnt_d;
  logic                sru_q, sru_d;
  logic                err_q, err_d;
  // Held low through reset and set on the first edge afterwards, so that
  // wordReady cannot rise until the cycle after reset is released.
  logic                live_q;

  logic                w_hs;
  logic                w_shifting;
  logic [1:0]          w_target;

  assign w_target   = wordIn[WORD_W-1 -: 2];
  assign w_shifting = (state_q == S_SHIFT) && !abort;

  assign wordReady          = live_q && !abort &&
                              ((state_q == S_IDLE) || (state_q == S_LOAD));
  assign w_hs               = wordValid && wordReady;
  assign smuStreamValid     = w_shifting && !sru_q;
  assign sruStreamValid     = w_shifting && sru_q;
  assign bitstreamSerialOut = w_shifting && shift_q[0];
  assign busy               = (state_q != S_IDLE);
  assign done               = (state_q == S_DONE);
  assign err                = err_q;

  always_ff @(posedge cfgClk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      rem_q   <= '0;
      bcnt_q  <= '0;
      sru_q   <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
      bcnt_q  <= bcnt_d;
      sru_q   <= sru_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    bcnt_d  = bcnt_q;
    sru_d   = sru_q;
    err_d   = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_hs) begin
            if (w_target == 2'b01 || w_target == 2'b10) begin
              sru_d = (w_target == 2'b10);
              rem_d = wordIn[LEN_W-1:0];
              state_d = (wordIn[LEN_W-1:0] == '0) ? S_DONE : S_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            shift_d = wordIn;
            bcnt_d  = '0;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          shift_d = shift_q >> 1;
          rem_d   = rem_q - LEN_W'(1);
          bcnt_d  = bcnt_q + c_BCNT_W'(1);
          // The length check wins over the word boundary so that a transfer
          // ending mid-word drops the unused upper bits of the final word.
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else if (bcnt_q == c_BCNT_W'(WORD_W - 1)) begin
            state_d = S_LOAD;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfg_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_stream_loader
// Purpose  : Self-checking bench for cfg_stream_loader: table of transfer
//            vectors plus hand-written reset, abort and reset-release cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_cfg_stream_loader;

  logic        cfgClk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wordIn = '0;
  logic        wordValid = 1'b0;
  logic        abort = 1'b0;
  logic        wordReady, bitstreamSerialOut, smuStreamValid, sruStreamValid;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  cfg_stream_loader #(.WORD_W(32), .LEN_W(16)) dut (
    .cfgClk             (cfgClk),
    .rst                (rst),
    .wordIn             (wordIn),
    .wordValid          (wordValid),
    .wordReady          (wordReady),
    .abort              (abort),
    .bitstreamSerialOut (bitstreamSerialOut),
    .smuStreamValid     (smuStreamValid),
    .sruStreamValid     (sruStreamValid),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  always #5 cfgClk = ~cfgClk;

  // Monotonic monitor counters, sampled on the falling edge.
  int   tot_bits = 0, smu_cnt = 0, sru_cnt = 0, runs = 0;
  int   done_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int   both_viol = 0, zero_viol = 0;
  logic prev_v = 1'b0;
  logic bits_log [0:4095];

  always @(negedge cfgClk) begin
    if (smuStreamValid || sruStreamValid) begin
      if (tot_bits < 4096) bits_log[tot_bits] = bitstreamSerialOut;
      tot_bits++;
      if (!prev_v) runs++;
    end
    if (smuStreamValid) smu_cnt++;
    if (sruStreamValid) sru_cnt++;
    if (smuStreamValid && sruStreamValid) both_viol++;
    if (!smuStreamValid && !sruStreamValid && bitstreamSerialOut) zero_viol++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (busy) busy_cnt++;
    prev_v = smuStreamValid || sruStreamValid;
  end

  typedef struct {
    logic [31:0] hdr;
    int          npay;
    logic [31:0] p0;
    logic [31:0] p1;
    int          exp_smu;
    int          exp_sru;
    logic [63:0] exp_bits;
    int          exp_runs;
    int          exp_done;
    int          exp_err;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cfgClk);
    #1;
  endtask

  // Present a word and hold it until it is accepted (bounded wait).
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    wordIn = w;
    wordValid = 1'b1;
    while (!wordReady && n < 300) begin
      tick();
      n++;
    end
    chk("handshake_timeout", longint'(wordReady), 1);
    tick();
    wordValid = 1'b0;
    wordIn = '0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int b_bits, b_smu, b_sru, b_runs, b_done, b_err, b_busy, nb, n;
    logic [63:0] got;
    b_bits = tot_bits; b_smu = smu_cnt; b_sru = sru_cnt; b_runs = runs;
    b_done = done_cnt; b_err = err_cnt; b_busy = busy_cnt;
    send_word(v.hdr);
    if (v.npay > 0) send_word(v.p0);
    if (v.npay > 1) send_word(v.p1);
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, longint'(busy), 0);
    repeat (3) tick();
    nb = tot_bits - b_bits;
    got = '0;
    for (int i = 0; i < nb && i < 64; i++) got[i] = bits_log[b_bits + i];
    chk({name, "_smu_bits"}, smu_cnt - b_smu, v.exp_smu);
    chk({name, "_sru_bits"}, sru_cnt - b_sru, v.exp_sru);
    chk({name, "_data"}, got, v.exp_bits);
    chk({name, "_runs"}, runs - b_runs, v.exp_runs);
    chk({name, "_done"}, done_cnt - b_done, v.exp_done);
    chk({name, "_err"}, err_cnt - b_err, v.exp_err);
    if (v.exp_err != 0) chk({name, "_busy"}, busy_cnt - b_busy, 0);
  endtask

  vec_t vecs [8];
  int   b_done, b_bits, b_busy;

  initial begin
    //        hdr           np p0            p1            smu sru bits                  runs done err
    vecs[0] = '{32'h4000_0008, 1, 32'h0000_00A5, 32'h0,        8,  0, 64'h0000_0000_0000_00A5, 1, 1, 0};
    vecs[1] = '{32'h8000_0028, 2, 32'hFFFF_FFFF, 32'h0,        0, 40, 64'h0000_0000_FFFF_FFFF, 2, 1, 0};
    vecs[2] = '{32'hC000_0010, 0, 32'h0,         32'h0,        0,  0, 64'h0,                   0, 0, 1};
    vecs[3] = '{32'h4000_0000, 0, 32'h0,         32'h0,        0,  0, 64'h0,                   0, 1, 0};
    vecs[4] = '{32'h0000_0005, 0, 32'h0,         32'h0,        0,  0, 64'h0,                   0, 0, 1};
    vecs[5] = '{32'h4000_0023, 2, 32'h1234_5678, 32'hFFFF_FFFD, 35, 0, 64'h0000_0005_1234_5678, 2, 1, 0};
    vecs[6] = '{32'h8000_0020, 1, 32'hDEAD_BEEF, 32'h0,        0, 32, 64'h0000_0000_DEAD_BEEF, 1, 1, 0};
    vecs[7] = '{32'h7FAB_0003, 1, 32'hFFFF_FFF6, 32'h0,        3,  0, 64'h0000_0000_0000_0006, 1, 1, 0};

    // Reset state and release timing.
    repeat (3) tick();
    chk("rst_ready", wordReady, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {bitstreamSerialOut, smuStreamValid, sruStreamValid, done, err}, 0);
    rst = 1'b0;
    #1;
    chk("ready_release_cycle", wordReady, 0);
    tick();
    chk("ready_after_release", wordReady, 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an SMU transfer, during bit 5.
    send_word(32'h4000_0008);
    send_word(32'h0000_00A5);
    repeat (5) tick();
    chk("mid_smu_valid", smuStreamValid, 1);
    chk("mid_bit5", bitstreamSerialOut, 1);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {wordReady, bitstreamSerialOut, smuStreamValid, sruStreamValid, busy, done, err}, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_vec('{32'h8000_0004, 1, 32'h0000_000F, 32'h0, 0, 4, 64'hF, 1, 1, 0}, "post_rst");

    // Abort while waiting in LOAD between words.
    send_word(32'h4000_0040);
    send_word(32'h0000_0001);
    for (int n = 0; n < 40 && !wordReady; n++) tick();
    chk("reach_load", wordReady, 1);
    b_done = done_cnt; b_bits = tot_bits;
    abort = 1'b1; wordValid = 1'b1; wordIn = 32'hFFFF_FFFF;
    #1;
    chk("abort_ready", wordReady, 0);
    tick();
    abort = 1'b0; wordValid = 1'b0; wordIn = '0;
    chk("abort_idle", busy, 0);
    repeat (3) tick();
    chk("abort_no_done", done_cnt - b_done, 0);
    chk("abort_no_bits", tot_bits - b_bits, 0);

    // Abort in IDLE blocks a presented header.
    b_done = done_cnt; b_busy = busy_cnt;
    abort = 1'b1; wordValid = 1'b1; wordIn = 32'h4000_0000;
    #1;
    chk("idle_abort_ready", wordReady, 0);
    tick();
    abort = 1'b0; wordValid = 1'b0; wordIn = '0;
    repeat (3) tick();
    chk("idle_abort_no_done", done_cnt - b_done, 0);
    chk("idle_abort_no_busy", busy_cnt - b_busy, 0);

    run_vec(vecs[0], "after_abort");

    chk("both_valids", both_viol, 0);
    chk("serial_zero", zero_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
